// File: rtl/audio_seq_pkg.sv
// Shared types and defaults for the audio frame sequencer.
package audio_seq_pkg;

  localparam int SEQ_DATA_W      = 16;
  localparam int SEQ_TIMEOUT_CYC = 1024;
  localparam int SEQ_CNT_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DISPATCH,
    WAIT,
    EMIT
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_DATA_W-1:0] left;
    logic [SEQ_DATA_W-1:0] right;
  } frame_t;

endpackage

// File: rtl/audio_seq_out_slot.sv
// Single-channel DAC output holding register: load strobe, valid/ready, done flag.
module audio_seq_out_slot
  import audio_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              done
);

  logic done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data   <= '0;
      valid  <= 1'b0;
      done_q <= 1'b0;
    end else if (load) begin
      data   <= load_data;
      valid  <= 1'b1;
      done_q <= 1'b0;
    end else if (valid && ready) begin
      valid  <= 1'b0;
      done_q <= 1'b1;
    end
  end

  // Includes the handshake of the current cycle so EMIT can leave on that edge.
  assign done = done_q | (valid & ready);

endmodule

// File: rtl/audio_frame_sequencer.sv
// Stereo frame capture, engine dispatch or bypass, and DAC emit with timeout fallback.
// Build option AUDIO_SEQ_MONO_EN: left-only capture, frame {L, L}, right beats ignored.
//
// state    | meaning
// IDLE     | one cycle after reset release, inputs not ready
// CAPTURE  | filling L/R slots, stale engine responses flushed
// DISPATCH | frame offered to the engine
// WAIT     | awaiting engine response, timeout timer running
// EMIT     | frame held on the DAC channels until both handshake
module audio_frame_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DATA_W      = SEQ_DATA_W,
  parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC,
  parameter int CNT_W       = SEQ_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   left_in_data,
  input  logic                left_in_valid,
  output logic                left_in_ready,
  input  logic [DATA_W-1:0]   right_in_data,
  input  logic                right_in_valid,
  output logic                right_in_ready,
  input  logic                bypass,
  output logic [2*DATA_W-1:0] proc_req_data,
  output logic                proc_req_valid,
  input  logic                proc_req_ready,
  input  logic [2*DATA_W-1:0] proc_rsp_data,
  input  logic                proc_rsp_valid,
  output logic                proc_rsp_ready,
  output logic [DATA_W-1:0]   left_out_data,
  output logic                left_out_valid,
  input  logic                left_out_ready,
  output logic [DATA_W-1:0]   right_out_data,
  output logic                right_out_valid,
  input  logic                right_out_ready,
  output logic [CNT_W-1:0]    drop_count,
  output logic [CNT_W-1:0]    timeout_count
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] slot_l_q, slot_r_q;
  logic              l_full_q, r_full_q;
  logic [TMR_W-1:0]  timer_q;
  logic [CNT_W-1:0]  drop_q, tout_q, drop_d;

  logic              in_rdy, l_store, r_store, l_drop, r_drop;
  logic              l_full_n, r_full_n, frame_done;
  logic [DATA_W-1:0] l_val_n, r_val_n, req_r, rsp_l, rsp_r;
  logic [DATA_W-1:0] out_l_d, out_r_d;
  logic              load_raw, load_rsp, tout_hit, clear_slots, timer_load;
  logic              out_load, l_done, r_done;
  logic [1:0]        drop_n;
  logic [CNT_W:0]    drop_sum;

  assign in_rdy         = (state_q != IDLE);
  assign left_in_ready  = in_rdy;
  assign right_in_ready = in_rdy;

  assign l_store  = (state_q == CAPTURE) && left_in_valid && !l_full_q;
  assign l_drop   = in_rdy && left_in_valid && !l_store;
  assign l_full_n = l_full_q | l_store;
  assign l_val_n  = l_store ? left_in_data : slot_l_q;
  assign rsp_l    = proc_rsp_data[2*DATA_W-1:DATA_W];

`ifdef AUDIO_SEQ_MONO_EN
  assign r_store    = 1'b0;
  assign r_drop     = 1'b0;
  assign r_full_n   = 1'b0;
  assign frame_done = l_full_n;
  assign r_val_n    = l_val_n;
  assign req_r      = slot_l_q;
  assign rsp_r      = rsp_l;
`else
  assign r_store    = (state_q == CAPTURE) && right_in_valid && !r_full_q;
  assign r_drop     = in_rdy && right_in_valid && !r_store;
  assign r_full_n   = r_full_q | r_store;
  assign frame_done = l_full_n & r_full_n;
  assign r_val_n    = r_store ? right_in_data : slot_r_q;
  assign req_r      = slot_r_q;
  assign rsp_r      = proc_rsp_data[DATA_W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    load_raw    = 1'b0;
    load_rsp    = 1'b0;
    tout_hit    = 1'b0;
    clear_slots = 1'b0;
    timer_load  = 1'b0;
    case (state_q)
      IDLE: state_d = CAPTURE;
      CAPTURE: begin
        if (frame_done) begin
          if (bypass) begin
            state_d  = EMIT;
            load_raw = 1'b1;
          end else begin
            state_d = DISPATCH;
          end
        end
      end
      DISPATCH: begin
        if (proc_req_ready) begin
          state_d    = WAIT;
          timer_load = 1'b1;
        end
      end
      WAIT: begin
        // A response on the terminal cycle takes priority over the timeout.
        if (proc_rsp_valid) begin
          state_d  = EMIT;
          load_rsp = 1'b1;
        end else if (timer_q == '0) begin
          state_d  = EMIT;
          load_raw = 1'b1;
          tout_hit = 1'b1;
        end
      end
      EMIT: begin
        if (l_done && r_done) begin
          state_d     = CAPTURE;
          clear_slots = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_load = load_raw | load_rsp;
  assign out_l_d  = load_rsp ? rsp_l : l_val_n;
  assign out_r_d  = load_rsp ? rsp_r : r_val_n;

  assign drop_n   = {1'b0, l_drop} + {1'b0, r_drop};
  assign drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_n};
  assign drop_d   = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      slot_l_q <= '0;
      slot_r_q <= '0;
      l_full_q <= 1'b0;
      r_full_q <= 1'b0;
      timer_q  <= '0;
      drop_q   <= '0;
      tout_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clear_slots) begin
        l_full_q <= 1'b0;
        r_full_q <= 1'b0;
      end else begin
        l_full_q <= l_full_n;
        r_full_q <= r_full_n;
      end
      if (l_store) slot_l_q <= left_in_data;
      if (r_store) slot_r_q <= right_in_data;
      if (timer_load)
        timer_q <= TMR_LOAD;
      else if (state_q == WAIT && timer_q != '0)
        timer_q <= timer_q - TMR_W'(1);
      drop_q <= drop_d;
      if (tout_hit && tout_q != CNT_MAX) tout_q <= tout_q + CNT_W'(1);
    end
  end

  assign proc_req_valid = (state_q == DISPATCH);
  assign proc_req_data  = (state_q == DISPATCH) ? {slot_l_q, req_r} : '0;
  assign proc_rsp_ready = (state_q == CAPTURE) || (state_q == WAIT);
  assign drop_count     = drop_q;
  assign timeout_count  = tout_q;

  audio_seq_out_slot #(.DATA_W(DATA_W)) u_slot_l (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (out_l_d),
    .data      (left_out_data),
    .valid     (left_out_valid),
    .ready     (left_out_ready),
    .done      (l_done)
  );

  audio_seq_out_slot #(.DATA_W(DATA_W)) u_slot_r (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (out_r_d),
    .data      (right_out_data),
    .valid     (right_out_valid),
    .ready     (right_out_ready),
    .done      (r_done)
  );

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Self-checking bench for audio_frame_sequencer: directed scenarios plus random traffic vs a frame-level model.
module tb_audio_frame_sequencer;

  localparam int DW   = 16;
  localparam int TO   = 8;
  localparam int CW   = 5;
  localparam int DMAX = 31;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] left_in_data = '0, right_in_data = '0;
  logic          left_in_valid = 1'b0, right_in_valid = 1'b0;
  logic          left_in_ready, right_in_ready;
  logic          bypass = 1'b0;
  logic [2*DW-1:0] proc_req_data, proc_rsp_data = '0;
  logic          proc_req_valid, proc_req_ready = 1'b0;
  logic          proc_rsp_valid = 1'b0, proc_rsp_ready;
  logic [DW-1:0] left_out_data, right_out_data;
  logic          left_out_valid, right_out_valid;
  logic          left_out_ready = 1'b1, right_out_ready = 1'b1;
  logic [CW-1:0] drop_count, timeout_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_frame_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .left_in_data(left_in_data), .left_in_valid(left_in_valid), .left_in_ready(left_in_ready),
    .right_in_data(right_in_data), .right_in_valid(right_in_valid), .right_in_ready(right_in_ready),
    .bypass(bypass),
    .proc_req_data(proc_req_data), .proc_req_valid(proc_req_valid), .proc_req_ready(proc_req_ready),
    .proc_rsp_data(proc_rsp_data), .proc_rsp_valid(proc_rsp_valid), .proc_rsp_ready(proc_rsp_ready),
    .left_out_data(left_out_data), .left_out_valid(left_out_valid), .left_out_ready(left_out_ready),
    .right_out_data(right_out_data), .right_out_valid(right_out_valid), .right_out_ready(right_out_ready),
    .drop_count(drop_count), .timeout_count(timeout_count)
  );

  // Reference model: where the current frame is in its life, not how the RTL encodes it.
  localparam int M_IDLE = 0, M_CAP = 1, M_DISP = 2, M_WAIT = 3, M_EMIT = 4;
  int            ph, wcnt, mdrop, mtout;
  logic          mlf, mrf, mlv, mrv;
  logic [DW-1:0] ml, mr, mol, mor;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE; wcnt = 0; mdrop = 0; mtout = 0;
    mlf = 0; mrf = 0; mlv = 0; mrv = 0;
    ml = '0; mr = '0; mol = '0; mor = '0;
  endtask

  task automatic emit(input logic [DW-1:0] a, input logic [DW-1:0] b);
    mol = a; mor = b; mlv = 1; mrv = 1; ph = M_EMIT;
  endtask

  // Applies the spec rules for one clock edge to the current input values.
  task automatic model_edge();
    bit ls, rs;
    int nd;
    ls = (ph == M_CAP) && left_in_valid && !mlf;
    rs = (ph == M_CAP) && right_in_valid && !mrf;
    nd = 0;
    if (ph != M_IDLE) nd = int'(left_in_valid && !ls) + int'(right_in_valid && !rs);
    mdrop = (mdrop + nd > DMAX) ? DMAX : mdrop + nd;
    case (ph)
      M_IDLE: ph = M_CAP;
      M_CAP: begin
        if (ls) begin ml = left_in_data; mlf = 1; end
        if (rs) begin mr = right_in_data; mrf = 1; end
        if (mlf && mrf) begin
          if (bypass) emit(ml, mr);
          else ph = M_DISP;
        end
      end
      M_DISP: if (proc_req_ready) begin ph = M_WAIT; wcnt = 0; end
      M_WAIT: begin
        if (proc_rsp_valid) emit(proc_rsp_data[31:16], proc_rsp_data[15:0]);
        else if (wcnt == TO - 1) begin
          emit(ml, mr);
          if (mtout < DMAX) mtout++;
        end else wcnt++;
      end
      M_EMIT: begin
        if (mlv && left_out_ready) mlv = 0;
        if (mrv && right_out_ready) mrv = 0;
        if (!mlv && !mrv) begin ph = M_CAP; mlf = 0; mrf = 0; end
      end
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("l_in_rdy", 32'(left_in_ready), 32'(ph != M_IDLE));
    chk("r_in_rdy", 32'(right_in_ready), 32'(ph != M_IDLE));
    chk("req_vld", 32'(proc_req_valid), 32'(ph == M_DISP));
    chk("req_dat", proc_req_data, (ph == M_DISP) ? {ml, mr} : 32'h0);
    chk("rsp_rdy", 32'(proc_rsp_ready), 32'(ph == M_CAP || ph == M_WAIT));
    chk("l_out_vld", 32'(left_out_valid), 32'(mlv));
    chk("r_out_vld", 32'(right_out_valid), 32'(mrv));
    if (mlv) chk("l_out_dat", 32'(left_out_data), 32'(mol));
    if (mrv) chk("r_out_dat", 32'(right_out_data), 32'(mor));
    chk("drops", 32'(drop_count), 32'(mdrop));
    chk("touts", 32'(timeout_count), 32'(mtout));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input logic lv, input logic [DW-1:0] ld, input logic rv, input logic [DW-1:0] rd);
    left_in_valid = lv; left_in_data = ld; right_in_valid = rv; right_in_data = rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    #1;
    // Reset state
    do_reset();
    chk("rst_drop", 32'(drop_count), 32'h0);
    chk("rst_lin_rdy", 32'(left_in_ready), 32'h0);
    step();

    // Bypass path
    bypass = 1; left_out_ready = 1; right_out_ready = 1;
    set_in(1, 16'h1234, 0, 16'h0); step();
    set_in(0, 16'h0, 1, 16'hABCD); step();
    chk("byp_l", 32'(left_out_data), 32'h1234);
    chk("byp_r", 32'(right_out_data), 32'hABCD);
    chk("byp_vld", 32'({left_out_valid, right_out_valid}), 32'h3);
    set_in(0, 16'h0, 0, 16'h0); step();
    chk("byp_done", 32'({left_out_valid, right_out_valid, proc_rsp_ready}), 32'h1);

    // Processed path with request backpressure
    bypass = 0; proc_req_ready = 0;
    set_in(1, 16'h0001, 1, 16'h0002); step();
    set_in(0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("req_hold", proc_req_data, 32'h0001_0002);
      if (i < 2) step();
    end
    proc_req_ready = 1; step();
    proc_req_ready = 0; step();
    proc_rsp_valid = 1; proc_rsp_data = 32'h7FFF_8000; step();
    proc_rsp_valid = 0;
    chk("proc_l", 32'(left_out_data), 32'h7FFF);
    chk("proc_r", 32'(right_out_data), 32'h8000);
    step();

    // Timeout fallback and stale-response flush
    proc_req_ready = 1;
    set_in(1, 16'h0005, 1, 16'h0006); step();
    set_in(0, 16'h0, 0, 16'h0); step();
    for (int i = 0; i < TO - 1; i++) step();
    chk("to_still_wait", 32'({left_out_valid, proc_rsp_ready}), 32'h1);
    step();
    chk("to_raw", 32'({left_out_data, right_out_data}), 32'h0005_0006);
    chk("to_count", 32'(timeout_count), 32'h1);
    proc_rsp_valid = 1; proc_rsp_data = 32'hDEAD_BEEF; step();
    step();
    proc_rsp_valid = 0; bypass = 1;
    set_in(1, 16'h0011, 1, 16'h0022); step();
    chk("flush_out", 32'({left_out_data, right_out_data}), 32'h0011_0022);
    set_in(0, 16'h0, 0, 16'h0); step();

    // Drops
    set_in(1, 16'h0100, 0, 16'h0); step();
    set_in(1, 16'h0200, 0, 16'h0); step();
    chk("drop_one", 32'(drop_count), 32'h1);
    set_in(0, 16'h0, 1, 16'h0300); step();
    chk("drop_keep", 32'(left_out_data), 32'h0100);
    left_out_ready = 0; right_out_ready = 0;
    set_in(1, 16'h0400, 1, 16'h0500); step();
    chk("drop_two", 32'(drop_count), 32'h3);
    left_out_ready = 1; right_out_ready = 1;
    set_in(0, 16'h0, 0, 16'h0); step();

    // Output backpressure on the right channel
    right_out_ready = 0;
    set_in(1, 16'hAAAA, 1, 16'hBBBB); step();
    set_in(0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_r_dat", 32'(right_out_data), 32'hBBBB);
      step();
      chk("bp_l_drop", 32'(left_out_valid), 32'h0);
    end
    chk("bp_not_cap", 32'(proc_rsp_ready), 32'h0);
    right_out_ready = 1; step();
    chk("bp_cap", 32'({right_out_valid, proc_rsp_ready}), 32'h1);

    // Asynchronous reset while waiting on the engine
    bypass = 0; proc_req_ready = 1;
    set_in(1, 16'h0007, 1, 16'h0008); step();
    set_in(0, 16'h0, 0, 16'h0); step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_outs", 32'({left_out_valid, right_out_valid, proc_req_valid, proc_rsp_ready,
                          left_in_ready, right_in_ready}), 32'h0);
    chk("arst_cnt", 32'({drop_count, timeout_count}), 32'h0);
    chk("arst_ldat", 32'(left_out_data), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    step();
    chk("arst_cap", 32'(left_in_ready), 32'h1);

    // Drop counter saturation (+2 per cycle crossing all-ones)
    proc_req_ready = 0;
    set_in(1, 16'h0009, 1, 16'h000A);
    for (int i = 0; i < 18; i++) step();
    chk("drop_sat", 32'(drop_count), 32'(DMAX));
    set_in(0, 16'h0, 0, 16'h0);

    // Randomized traffic with periodic resets
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 59) do_reset();
      set_in(($urandom_range(0, 2) == 0), DW'($urandom), ($urandom_range(0, 2) == 0), DW'($urandom));
      bypass          = ($urandom_range(0, 3) == 0);
      proc_req_ready  = ($urandom_range(0, 1) == 0);
      proc_rsp_valid  = ($urandom_range(0, 7) == 0);
      proc_rsp_data   = $urandom;
      left_out_ready  = ($urandom_range(0, 2) != 0);
      right_out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
Sequences stereo audio through the pitch-processing engine. Collects one left and one right sample from the codec ADC stream sources into a frame. Dispatches the frame to a processing engine over a request/response handshake, or bypasses the engine. Drives the result to the codec DAC left/right sinks with full Avalon-ST valid/ready compliance, a response timeout fallback, and drop/timeout statistics.

Parameters:
DATA_W, 16, sample width per channel
TIMEOUT_CYC, 1024, cycles in WAIT without a response before falling back to the raw frame
CNT_W, 16, width of the saturating statistic counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
left_in_data  in  DATA_W  ADC left sample
left_in_valid  in  1  left sample valid
left_in_ready  out  1  left sink ready
right_in_data  in  DATA_W  ADC right sample
right_in_valid  in  1  right sample valid
right_in_ready  out  1  right sink ready
bypass  in  1  1 = skip the processing engine
proc_req_data  out  2*DATA_W  frame to engine, {left, right}
proc_req_valid  out  1  request valid
proc_req_ready  in  1  engine accepts request
proc_rsp_data  in  2*DATA_W  processed frame, {left, right}
proc_rsp_valid  in  1  response valid
proc_rsp_ready  out  1  sequencer accepts response
left_out_data  out  DATA_W  DAC left sample
left_out_valid  out  1  left output valid
left_out_ready  in  1  DAC left ready
right_out_data  out  DATA_W  DAC right sample
right_out_valid  out  1  right output valid
right_out_ready  in  1  DAC right ready
drop_count  out  CNT_W  dropped input beats, saturating
timeout_count  out  CNT_W  engine timeouts, saturating

Behaviour:
- Transfer rule: a beat transfers on any clk edge where valid and ready are both 1.
- Reset: asynchronous. All outputs are 0; state is IDLE; slots, timer and counters are cleared. Reset mid-operation abandons the frame and asserts no outputs.
- Codec inputs are never backpressured: left_in_ready = right_in_ready = 1 in every state except IDLE.
- States:
  - IDLE: occupies exactly 1 cycle after reset deasserts, then goes to CAPTURE.
  - CAPTURE:
    - A left beat is stored if the L slot is empty; a right beat is stored if the R slot is empty.
    - Once both slots are full, bypass is sampled on that edge: bypass = 1 goes to EMIT with the raw frame; bypass = 0 goes to DISPATCH.
    - L and R arriving in the same cycle both store.
  - DISPATCH:
    - proc_req_valid = 1 and proc_req_data = {L, R}, held stable until proc_req_ready.
    - On the handshake, go to WAIT with the timer cleared.
  - WAIT:
    - proc_rsp_ready = 1. A response handshake latches proc_rsp_data as the output frame and goes to EMIT.
    - The timer increments each cycle. If it reaches TIMEOUT_CYC-1 with no response, go to EMIT with the raw frame and increment timeout_count.
    - A response on the timeout cycle wins and no timeout is counted.
  - EMIT:
    - left_out_valid and right_out_valid assert together, and each drops independently after its own handshake. Data is held stable while valid.
    - When both channels are done, slots clear and the state goes to CAPTURE.
- Dropped beats increment drop_count: any input beat in DISPATCH, WAIT or EMIT, or in CAPTURE while its slot is already full. Two simultaneous drops add 2. The stored sample is never overwritten.
- Stale responses: proc_rsp_ready = 1 in CAPTURE, and any response accepted there is discarded (flushes late engine responses). proc_rsp_ready = 0 in DISPATCH and EMIT.
- Latency:
  - Bypass path: the second captured sample at edge t gives out valid at edge t+1.
  - Processed path: proc_req_valid at t+1; a response accepted at s gives out valid at s+1.
- Counters saturate at all-ones; there is no wrap.

Optional Feature:
AUDIO_SEQ_MONO_EN
- Defined: right input is ignored. right_in_ready = 1, right beats are discarded and not counted as drops. CAPTURE completes on the left slot alone. The frame is {L, L}, and both DAC channels carry left-derived data.
- Undefined: stereo behaviour as specified above.

Decomposition:
- Package audio_seq_pkg: state enum (IDLE, CAPTURE, DISPATCH, WAIT, EMIT); frame_t struct {left, right} of DATA_W each; default constants for TIMEOUT_CYC and CNT_W.
- Sub-module audio_seq_out_slot: a single-channel output holding register with a load strobe, valid/ready and a done flag. Instantiated twice (left, right).
- FSM, slots, timer and counters live in the top module.

Test Plan:
- Bypass: bypass=1, L=0x1234 then R=0xABCD, both out_ready=1 -> next cycle left_out=0x1234, right_out=0xABCD, both valid for 1 cycle; state returns to CAPTURE.
- Processed: bypass=0, L=0x0001, R=0x0002, proc_req_ready low for 3 cycles -> proc_req_data=0x00010002 held stable for 4 cycles; rsp 0x7FFF8000 -> left_out=0x7FFF, right_out=0x8000.
- Timeout: TIMEOUT_CYC=8, no response -> after 8 WAIT cycles outputs carry the raw frame and timeout_count=1; a late response arriving in the next CAPTURE is accepted, discarded and never output.
- Drops: second left beat while the L slot is full -> drop_count=1 and the first sample is emitted; L and R valid together during EMIT -> drop_count increases by 2.
- Backpressure: right_out_ready=0 for 5 cycles, left_out_ready=1 -> left valid for 1 cycle; right data stable for 6 cycles; CAPTURE entered only after the right handshake.
- Reset in WAIT: reset asserted asynchronously -> all outputs and counters 0 without a clock edge; IDLE for 1 cycle after release, then CAPTURE.
